// File: rtl/fdiv_seq_if.sv
// Command interface between the FPU sequencer and the sequential divider.
// The sequencer drives the master side; the divider is the slave.
interface fdiv_seq_if #(
    parameter int unsigned W = 31
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         ovf;
    logic         unf;
    logic         dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, out, ovf, unf, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, out, ovf, unf, dz
    );
endinterface

// File: rtl/fdiv_seq.sv
// Multi-cycle MIX floating-point divider: byte pre-normalisation, restoring
// division retiring RADIX_BITS quotient bits per cycle, post-normalise and round.
module fdiv_seq #(
    parameter int unsigned BYTE       = 6,
    parameter int unsigned FBYTES     = 4,
    parameter int unsigned RADIX_BITS = 3,
    parameter int          EBIAS      = 32
) (
    input  logic      clk,
    input  logic      rst,
    fdiv_seq_if.slave bus
);
    localparam int unsigned F    = FBYTES * BYTE;
    localparam int unsigned W    = 1 + BYTE + F;
    localparam int unsigned R    = RADIX_BITS;
    localparam int unsigned N    = (F + BYTE + 1 + R - 1) / R;
    localparam int unsigned QB   = N * R;
    localparam int unsigned D    = QB - BYTE - F;
    localparam int unsigned EW   = BYTE + 3;
    localparam int unsigned RW   = F + R + 1;
    localparam int unsigned CW   = $clog2(N + 1);
    localparam int unsigned MAXM = (1 << R) - 1;

    typedef enum logic [1:0] {IDLE, NORM, DIV, RND} state_t;

    state_t        state_q, state_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] eu_q, eu_d, ev_q, ev_d;
    logic [F-1:0]  fu_q, fu_d, fv_q, fv_d;
    logic [RW-1:0] r_q, r_d;
    logic [QB-1:0] s_q, s_d;
    logic [QB-1:0] q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_q, out_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, dz_q, dz_d;
    logic          done_q, done_d, busy_q, busy_d;

    // One restoring step: largest multiple m*fv not exceeding the shifted remainder
    logic [RW-1:0] r_sh, r_div, prod;
    logic [R-1:0]  m_div;

    always_comb begin
        r_sh  = (r_q << R) | RW'(s_q[QB-1 -: R]);
        r_div = r_sh;
        m_div = '0;
        prod  = '0;
        for (int unsigned m = 1; m <= MAXM; m++) begin
            prod = RW'(m) * RW'(fv_q);
            if (r_sh >= prod) begin
                r_div = r_sh - prod;
                m_div = R'(m);
            end
        end
    end

    // Post-normalise, round half-up on the first dropped bit, exponent range checks
    logic              q_big, rnd_up, ovf_c, unf_c;
    logic [QB-BYTE-1:0] qsel;
    logic [F:0]        fsum;
    logic [F-1:0]      frac_fin;
    logic [EW-1:0]     e_base, e_fin;

    always_comb begin
        q_big  = (q_q >> (QB - BYTE)) != '0;
        qsel   = q_big ? (QB-BYTE)'(q_q >> BYTE) : q_q[QB-BYTE-1:0];
        rnd_up = qsel[D-1:0] >= D'(1 << (D - 1));
        fsum   = (F+1)'(qsel[QB-BYTE-1 -: F]) + (F+1)'(rnd_up);
        e_base = eu_q - ev_q + EW'(EBIAS) + EW'(q_big);
        if (fsum[F]) begin
            frac_fin = F'(1) << (F - BYTE);
            e_fin    = e_base + EW'(1);
        end else begin
            frac_fin = fsum[F-1:0];
            e_fin    = e_base;
        end
        unf_c = e_fin[EW-1];
        ovf_c = !e_fin[EW-1] && (e_fin[EW-2:BYTE] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            eu_q    <= '0;
            ev_q    <= '0;
            fu_q    <= '0;
            fv_q    <= '0;
            r_q     <= '0;
            s_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            eu_q    <= eu_d;
            ev_q    <= ev_d;
            fu_q    <= fu_d;
            fv_q    <= fv_d;
            r_q     <= r_d;
            s_q     <= s_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        eu_d    = eu_q;
        ev_d    = ev_q;
        fu_d    = fu_q;
        fv_d    = fv_q;
        r_d     = r_q;
        s_d     = s_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d  = bus.dividend[W-1] ^ bus.divisor[W-1];
                    eu_d    = EW'(bus.dividend[W-2 -: BYTE]);
                    ev_d    = EW'(bus.divisor[W-2 -: BYTE]);
                    fu_d    = bus.dividend[F-1:0];
                    fv_d    = bus.divisor[F-1:0];
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    dz_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (fv_q == '0) begin
                    out_d   = '0;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (fu_q == '0) begin
                    out_d   = {sign_q, {(W-1){1'b0}}};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (fu_q[F-1 -: BYTE] == '0 || fv_q[F-1 -: BYTE] == '0) begin
                    if (fu_q[F-1 -: BYTE] == '0) begin
                        fu_d = fu_q << BYTE;
                        eu_d = eu_q - EW'(1);
                    end
                    if (fv_q[F-1 -: BYTE] == '0) begin
                        fv_d = fv_q << BYTE;
                        ev_d = ev_q - EW'(1);
                    end
                end else begin
                    // fu*2^(QB-BYTE) split as (fu>>BYTE)*2^QB + low bits fed in R at a time
                    r_d     = RW'(fu_q >> BYTE);
                    s_d     = {fu_q[BYTE-1:0], {(QB-BYTE){1'b0}}};
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                r_d   = r_div;
                s_d   = s_q << R;
                q_d   = (q_q << R) | QB'(m_div);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = RND;
                end
            end
            RND: begin
                out_d   = unf_c ? {sign_q, {(W-1){1'b0}}} : {sign_q, e_fin[BYTE-1:0], frac_fin};
                ovf_d   = ovf_c;
                unf_d   = unf_c;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out  = out_q;
    assign bus.ovf  = ovf_q;
    assign bus.unf  = unf_q;
    assign bus.dz   = dz_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_fdiv_seq.sv
// Scoreboard bench for fdiv_seq: directed operand pairs with hand-computed
// results and latencies, plus reset and start-while-busy scenarios.
module tb_fdiv_seq;
    localparam int unsigned W = 31;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fdiv_seq_if #(.W(W)) bus();

    fdiv_seq #(.BYTE(6), .FBYTES(4), .RADIX_BITS(3), .EBIAS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         ovf;
        logic         unf;
        logic         dz;
        int unsigned  start_edge;
        int unsigned  lat;
        string        name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int unsigned edge_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned d0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic s, input int unsigned e, input int unsigned f);
        return {s, 6'(e), 24'(f)};
    endfunction

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Monitor: every done pulse pops one expected result
    initial forever begin
        @(negedge clk);
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 required no done (scoreboard empty)");
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_out"}, 32'(bus.out), 32'(mon_e.out));
                chk({mon_e.name, "_ovf"}, 32'(bus.ovf), 32'(mon_e.ovf));
                chk({mon_e.name, "_unf"}, 32'(bus.unf), 32'(mon_e.unf));
                chk({mon_e.name, "_dz"},  32'(bus.dz),  32'(mon_e.dz));
                chk({mon_e.name, "_lat"}, 32'(edge_cnt - mon_e.start_edge), 32'(mon_e.lat));
            end
        end
    end

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
        @(negedge clk);
        chk({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic launch(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eo, input logic eovf, input logic eunf,
                          input logic edz, input int unsigned lat);
        exp_t x;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        x.out        = eo;
        x.ovf        = eovf;
        x.unf        = eunf;
        x.dz         = edz;
        x.start_edge = edge_cnt + 1;
        x.lat        = lat;
        x.name       = name;
        sbq.push_back(x);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic eovf, input logic eunf,
                         input logic edz, input int unsigned lat);
        launch(name, a, b, eo, eovf, eunf, edz, lat);
        wait_drain(name);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_out"},  32'(bus.out),  32'd0);
        chk({name, "_ovf"},  32'(bus.ovf),  32'd0);
        chk({name, "_unf"},  32'(bus.unf),  32'd0);
        chk({name, "_dz"},   32'(bus.dz),   32'd0);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;

        issue("basic",    mk(0,32,'h400000), mk(0,32,'h800000), mk(0,32,'h800000), 0,0,0, 13);
        issue("qge1",     mk(0,32,'h800000), mk(0,32,'h400000), mk(0,33,'h080000), 0,0,0, 13);
        issue("qge1_neg", mk(0,32,'h800000), mk(1,32,'h400000), mk(1,33,'h080000), 0,0,0, 13);
        issue("rnd_down", mk(1,32,'h400000), mk(0,32,'hC00000), mk(1,32,'h555555), 0,0,0, 13);
        issue("rnd_up",   mk(0,32,'h800000), mk(0,32,'hC00000), mk(0,32,'hAAAAAB), 0,0,0, 13);
        issue("rnd_big",  mk(0,32,'hFFFFFF), mk(0,32,'h800000), mk(0,33,'h080000), 0,0,0, 13);
        issue("norm_u",   mk(0,34,'h000400), mk(0,32,'h800000), mk(0,32,'h800000), 0,0,0, 15);
        issue("norm_v",   mk(0,32,'h800000), mk(0,33,'h020000), mk(0,33,'h040000), 0,0,0, 14);
        issue("norm_uv",  mk(0,34,'h000400), mk(0,33,'h020000), mk(0,32,'h800000), 0,0,0, 15);
        issue("dz",       mk(0,32,'h400000), mk(0,32,'h000000), mk(0,0,0),         0,0,1, 1);
        issue("dz_both",  mk(0,0,'h000000),  mk(1,5,'h000000),  mk(0,0,0),         0,0,1, 1);
        issue("zero_u",   mk(0,10,'h000000), mk(1,32,'h800000), mk(1,0,0),         0,0,0, 1);
        issue("ovf",      mk(0,63,'h800000), mk(0,0,'h400000),  mk(0,32,'h080000), 1,0,0, 13);

        // Reset at edge 5 of an operation: everything clears and no done follows
        @(negedge clk);
        bus.dividend = mk(0,32,'h400000);
        bus.divisor  = mk(0,32,'h800000);
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        d0 = done_cnt;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_cleared("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        issue("unf",      mk(0,0,'h400000),  mk(0,63,'h400000), mk(0,0,0),         0,1,0, 13);

        // A second start while busy must be ignored
        d0 = done_cnt;
        launch("busy_start", mk(0,32,'h800000), mk(1,32,'h400000), mk(1,33,'h080000), 0,0,0, 13);
        repeat (2) @(negedge clk);
        bus.dividend = mk(0,32,'h400000);
        bus.divisor  = mk(0,32,'h000000);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_drain("busy_start");
        repeat (20) @(negedge clk);
        chk("busy_start_one_done", 32'(done_cnt - d0), 32'd1);

        issue("after",    mk(0,32,'h800000), mk(0,32,'hC00000), mk(0,32,'hAAAAAB), 0,0,0, 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
